// File: rtl/approx_muld2.sv
// 8x8 unsigned approximate multiplier: columns 3..7 are compressed by lossy 4:2 cells,
// everything else is summed exactly; the product is registered (one-cycle latency).
module approx_muld2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    output logic [15:0] s
);

    // Bit j of row i is pp(i,j) = a[j] & b[i], weight 2^(i+j).
    logic [7:0]  pp [8];
    logic [15:0] row [8];
    logic [4:0]  cell_s;
    logic [4:0]  cell_c;
    logic        hi_s;
    logic        hi_c;
    logic [15:0] s_vec;
    logic [15:0] c_vec;
    logic [15:0] product;

    function automatic logic approx_sum(input logic x1, input logic x2,
                                        input logic x3, input logic x4);
        return (x1 ^ x2) | (x3 ^ x4);
    endfunction

    function automatic logic approx_carry(input logic x1, input logic x2,
                                          input logic x3, input logic x4);
        return (x1 & x2) | (x3 & x4);
    endfunction

    // A pp survives into the exact sum unless an approximate cell has consumed it.
    function automatic logic [7:0] keep_mask(input int i);
        logic [7:0] mask;
        mask = '0;
        for (int j = 0; j < 8; j++) begin
            if (!(((i + j) >= 3 && (i + j) <= 7 && i <= 3) || (i + j) == 7))
                mask = mask | (8'b1 << j);
        end
        return mask;
    endfunction

    genvar gi, gk;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rows
            localparam logic [7:0] KEEP = keep_mask(gi);
            assign pp[gi]  = a & {8{b[gi]}};
            assign row[gi] = {8'b0, pp[gi] & KEEP} << gi;
        end

        // Group 0 of column k takes i = 0..3, in increasing i.
        for (gk = 3; gk <= 7; gk++) begin : g_cells
            assign cell_s[gk-3] = approx_sum(pp[0][gk], pp[1][gk-1], pp[2][gk-2], pp[3][gk-3]);
            assign cell_c[gk-3] = approx_carry(pp[0][gk], pp[1][gk-1], pp[2][gk-2], pp[3][gk-3]);
        end
    endgenerate

    // Column 7 is the only one deep enough for a second group (i = 4..7).
    assign hi_s = approx_sum(pp[4][3], pp[5][2], pp[6][1], pp[7][0]);
    assign hi_c = approx_carry(pp[4][3], pp[5][2], pp[6][1], pp[7][0]);

    assign s_vec = {8'b0, cell_s, 3'b0};
    assign c_vec = {7'b0, cell_c, 4'b0};

    always_comb begin
        product = s_vec + c_vec
                + ({15'b0, hi_s} << 7) + ({15'b0, hi_c} << 8)
                + row[0] + row[1] + row[2] + row[3]
                + row[4] + row[5] + row[6] + row[7];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            out_valid <= 1'b0;
        end else begin
            s         <= product;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_approx_muld2.sv
// Directed and exhaustive check of approx_muld2 against an independent column-wise model.
module tb_approx_muld2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic [15:0] s;

    int checks = 0;
    int passed = 0;

    approx_muld2 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .s         (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model built column by column: list column k in increasing i, cut into groups of four.
    function automatic int unsigned model(input logic [7:0] x, input logic [7:0] y);
        int unsigned sum;
        logic        bits [8];
        int          n;
        int          groups;
        logic        x1, x2, x3, x4;
        sum = 0;
        for (int k = 0; k <= 14; k++) begin
            n = 0;
            for (int i = 0; i < 8; i++) begin
                if (k - i >= 0 && k - i <= 7) begin
                    bits[n] = x[k-i] & y[i];
                    n++;
                end
            end
            groups = 0;
            if (k >= 3 && k <= 7) groups = (k == 7) ? 2 : 1;
            for (int g = 0; g < groups; g++) begin
                x1 = bits[4*g];
                x2 = bits[4*g+1];
                x3 = bits[4*g+2];
                x4 = bits[4*g+3];
                if ((x1 ^ x2) | (x3 ^ x4)) sum += (32'd1 << k);
                if ((x1 & x2) | (x3 & x4)) sum += (32'd1 << (k + 1));
            end
            for (int m = 4 * groups; m < n; m++)
                if (bits[m]) sum += (32'd1 << k);
        end
        return sum;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned exp_val;
        int unsigned exact;
        longint      total_err;
        int unsigned max_err;
        int          bound_violations;

        rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF;

        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF);
            checkOutput("reset_s", 32'(s), 32'd0);
            checkOutput("reset_valid", 32'(out_valid), 32'd0);
        end

        applyStimulus(1'b0, 1'b1, 8'd1, 8'd1);
        checkOutput("1x1", 32'(s), 32'd1);
        checkOutput("1x1_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'd255, 8'd1);
        checkOutput("255x1", 32'(s), 32'd255);
        applyStimulus(1'b0, 1'b1, 8'd1, 8'd255);
        checkOutput("1x255", 32'(s), 32'd255);
        applyStimulus(1'b0, 1'b1, 8'd8, 8'd8);
        checkOutput("8x8", 32'(s), 32'd64);
        applyStimulus(1'b0, 1'b1, 8'd255, 8'd255);
        checkOutput("255x255", 32'(s), 32'd64273);
        applyStimulus(1'b0, 1'b1, 8'd0, 8'd200);
        checkOutput("0x200", 32'(s), 32'd0);

        applyStimulus(1'b0, 1'b1, 8'd15, 8'd15);
        checkOutput("stream_15x15", 32'(s), 32'd209);
        checkOutput("stream_v0", 32'(out_valid), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'd255, 8'd1);
        checkOutput("stream_255x1", 32'(s), 32'd255);
        checkOutput("stream_v1", 32'(out_valid), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'd0, 8'd9);
        checkOutput("stream_0x9", 32'(s), 32'd0);
        checkOutput("stream_v2", 32'(out_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'd3, 8'd5);
        checkOutput("idle_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_s_loads", 32'(s), 32'd15);

        applyStimulus(1'b0, 1'b1, 8'd15, 8'd15);
        applyStimulus(1'b1, 1'b1, 8'd255, 8'd255);
        checkOutput("midreset_s", 32'(s), 32'd0);
        checkOutput("midreset_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd7, 8'd7);
        checkOutput("post_reset_idle", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd16, 8'd77);
        checkOutput("post_reset_first", 32'(s), 32'd1232);
        checkOutput("post_reset_valid", 32'(out_valid), 32'd1);

        total_err = 0;
        max_err = 0;
        bound_violations = 0;
        for (int av = 0; av < 256; av++) begin
            for (int bv = 0; bv < 256; bv++) begin
                applyStimulus(1'b0, 1'b1, 8'(av), 8'(bv));
                exp_val = model(8'(av), 8'(bv));
                exact   = 32'(av) * 32'(bv);
                checkOutput($sformatf("sweep_%0dx%0d", av, bv), 32'(s), exp_val);
                if (32'(s) > exact) bound_violations++;
                else begin
                    total_err += longint'(exact - 32'(s));
                    if (exact - 32'(s) > max_err) max_err = exact - 32'(s);
                end
            end
        end
        checkOutput("sweep_never_above_exact", 32'(bound_violations), 32'd0);
        checkOutput("sweep_max_error", max_err, 32'd752);
        $display("[TB] mean error distance %0f, max error distance %0d",
                 real'(total_err) / 65536.0, max_err);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/approx_muld2.md
APPROX_MULD2 -- requirements
Module: approx_muld2

Interface
REQ-001 Clock and reset SHALL be one clock with a synchronous, active-high reset, on ports clk and rst.
REQ-002 Port list (name, direction, width, meaning) SHALL be exactly the following:
  clk        input   1   rising-edge clock
  rst        input   1   synchronous active-high reset
  in_valid   input   1   a/b qualify this cycle
  a          input   8   unsigned multiplicand
  b          input   8   unsigned multiplier
  out_valid  output  1   s holds a new product
  s          output  16  registered approximate product
REQ-003 The block SHALL have no parameters; widths are fixed at 8x8 -> 16.

Function
REQ-004 Partial products SHALL be formed as pp(i,j) = a[j] & b[i], for i,j in 0..7, with weight 2^(i+j).
REQ-005 Column k SHALL contain the pp(i,j) with i+j = k, ordered by increasing i.
REQ-006 Columns 0-2 and 8-14 SHALL be reduced exactly.
REQ-007 In columns 3..7, each group of four consecutive pps SHALL go through one approximate 4:2 cell, with x1..x4 taken in column order:
  - group 0 is i = 0..3;
  - column 7 also has group 1, i = 4..7;
  - any remaining pps (columns 4-6) stay exact.
REQ-008 Approximate cell outputs SHALL be:
  - S = (x1 XOR x2) OR (x3 XOR x4), at weight 2^k;
  - C = (x1 AND x2) OR (x3 AND x4), at weight 2^(k+1).
  No cell carry-in or carry-out exists.
REQ-009 The product SHALL be the exact unsigned sum of all remaining pps, all S bits and all C bits, each at its weight.
  - The result fits in 16 bits; no truncation occurs.
  - Error is never positive: the product is never larger than a*b.
REQ-010 Internal structure is free (half/full adders, exact 4:2 cells, final carry-propagate adder), provided every (a, b) gives the REQ-009 value bit-exactly.
REQ-011 On every rising clk edge with rst = 0:
  - s SHALL load the product of the current a and b;
  - out_valid SHALL load in_valid.
  Latency is 1 cycle.
REQ-012 s SHALL load when in_valid = 0 as well; out_valid = 0 marks s as don't-care for consumers.
REQ-013 Back-to-back operands SHALL be accepted every cycle; throughput is 1 product/cycle; there is no stall or backpressure.
REQ-014 There SHALL be no combinational path from inputs to outputs.
REQ-015 For either operand equal to 0, s SHALL be 0.
REQ-016 Any operand pair in which no column 3..7 receives four pps with nonzero approximation error SHALL produce the exact product. Example: a or b a power of two.

Reset
REQ-017 While rst = 1 at a rising clk edge, s SHALL become 16'h0000 and out_valid SHALL become 0, regardless of in_valid, a or b.
REQ-018 When rst is asserted mid-stream, the in-flight product SHALL be discarded.
REQ-019 The first valid result after rst deasserts SHALL appear one cycle after the first in_valid = 1 with rst = 0.
REQ-020 The power-up output value before the first reset is unspecified.

Verification
REQ-021 rst = 1 for 2 cycles with a = 8'hFF, b = 8'hFF, in_valid = 1 -> s = 0 and out_valid = 0 throughout.
REQ-022 a = 1, b = 1 -> s = 1 next cycle; a = 255, b = 1 -> s = 255; a = 1, b = 255 -> s = 255; a = 8, b = 8 -> s = 64 (exact cases).
REQ-023 a = 15, b = 15 -> s = 209 (exact 225; column 3 cell 1111 gives 2 instead of 4). a = 255, b = 255 -> s = 64273 (exact 65025; deficit 752).
REQ-024 a = 0, b = 200 -> s = 0.
REQ-025 Streaming: pairs (15,15), (255,1), (0,9) on consecutive cycles with in_valid = 1 -> s = 209, 255, 0 on the following consecutive cycles, with out_valid = 1 each cycle. Then in_valid = 0 -> out_valid = 0 on the next cycle.
REQ-026 Exhaustive sweep: all 65536 (a, b) pairs compared against a software model of REQ-004..REQ-009. Required: zero mismatches and s <= a*b always; report mean and maximum error distance.
